esdi_cmd_master: RTL
====================

ESDI_CMD_MASTER -- requirements
Module: esdi_cmd_master

Interface
REQ-001 Parameter DATA_SETUP, default 6: clocks command_data is held stable before transfer_req rises (≥50 ns at 100 MHz).
REQ-002 Parameter TIMEOUT, default 1_000_000: clocks allowed in any wait state before abort (10 ms at 100 MHz).
REQ-003 aclk  in  1  sole clock; all logic rising-edge.
REQ-004 areset  in  1  reset, asynchronous and active-high.
REQ-005 cmd_valid / cmd_ready  in / out  1 / 1  command word handshake.
REQ-006 cmd_data  in  16  command word, sent MSB first.
REQ-007 cmd_rsp_words  in  3  status words to read back after the command (0-7), sampled with cmd_data.
REQ-008 rsp_valid / rsp_ready  out / in  1 / 1  status word handshake.
REQ-009 rsp_data  out  16  received status word; rsp_parity_err  out  1  parity failure on that word.
REQ-010 done  out  1  one-cycle pulse at end of command; done_status  out  2  00 ok, 01 timeout, 10 attention, 11 parity error.
REQ-011 busy  out  1  high whenever state is not IDLE.
REQ-012 esdi_transfer_req, esdi_command_data  out  1  ESDI serial command lines to the drive.
REQ-013 esdi_transfer_ack, esdi_confstat_data, esdi_command_complete, esdi_attention  in  1  drive lines, asynchronous.

Function
REQ-014 All four ESDI inputs SHALL pass through 2-flop synchronizers; all logic below uses the synchronized copies.
REQ-015 States: IDLE, TX_SETUP, TX_REQ, TX_REL, RX_REQ, RX_REL, RX_HOLD, CMPL, and DONE. DONE lasts one cycle.
REQ-016 cmd_ready SHALL equal (state==IDLE). On accept, latch {cmd_data, ~^cmd_data} into a 17-bit shift register (odd parity over 17 bits), latch cmd_rsp_words, and clear the bit count. Next state is TX_SETUP.
REQ-017 TX_SETUP: drive command_data = shift[16]. After DATA_SETUP cycles, set transfer_req = 1 and go to TX_REQ.
REQ-018 TX_REQ: when ack is high, clear transfer_req, shift left, increment the bit count, and go to TX_REL. command_data SHALL hold its value until TX_REL exits.
REQ-019 TX_REL: when ack is low, go to TX_SETUP if the bit count is below 17.
REQ-020 TX_REL exit after 17 bits: clear command_data to 0, clear the bit count, then go to RX_REQ if the remaining word count is nonzero, else to CMPL.
REQ-021 RX_REQ: set transfer_req = 1. When ack is high, shift confstat into the LSB of the receive register, clear transfer_req, and go to RX_REL.
REQ-022 RX_REL: when ack is low, go to RX_REQ if fewer than 17 bits have been received, else to RX_HOLD.
REQ-023 RX_HOLD: rsp_valid = 1, rsp_data = rx[16:1]. rsp_parity_err = (~^rx[16:1] != rx[0]).
REQ-024 RX_HOLD exit: on rsp_valid&&rsp_ready, decrement the word count and go to RX_REQ, or to CMPL when the count reaches 0. No timeout applies in RX_HOLD.
REQ-025 CMPL: when command_complete is high, go to DONE.
REQ-026 DONE: pulse done with the status, then go to IDLE. Status is 11 if any word in the command had a parity error, else 00.
REQ-027 A wait counter SHALL clear on every state change. In TX_REQ, TX_REL, RX_REQ, RX_REL, and CMPL, counter == TIMEOUT SHALL force transfer_req = 0, command_data = 0, and status 01, then DONE.
REQ-028 Attention high in any non-IDLE state except DONE SHALL abort to DONE with status 10. Attention takes priority over both timeout and ack in the same cycle.
REQ-029 In IDLE, attention SHALL be ignored; cmd_valid is still accepted.

Reset
REQ-030 areset asserted SHALL immediately force: state IDLE, transfer_req 0, command_data 0, rsp_valid 0, done 0, and counters 0.
REQ-031 areset asserted SHALL also force synchronizers 0 and busy 0. Reset mid-bit aborts with no done pulse.
REQ-032 After reset release, cmd_ready SHALL be 1 on the first clock edge.

Configuration
REQ-033 Macro ESDI_CMD_PARITY_CHECK_EN defined: parity checking per REQ-023/026.
REQ-034 Macro ESDI_CMD_PARITY_CHECK_EN undefined: rsp_parity_err is tied 0, status 11 is never produced, and the receive parity bit is discarded.

Verification
REQ-035 Drive model acks every req after 8 clocks. Send cmd 0x1234 with rsp_words = 0. Required: 17 req pulses; captured bits 0x1234 with parity bit 0; complete raised; done with status 00.
REQ-036 Send cmd 0x0001 with rsp_words = 2. Drive returns 0xA5A5 (parity 1), then 0xFFFF (parity 1). Required: two rsp beats with those values; rsp_parity_err = 0; done status 00.
REQ-037 As REQ-036, but rsp_ready is held low for 100 clocks per word. Required: transfer_req stays 0 throughout the hold; no timeout.
REQ-038 Drive never acks bit 5. Required: after TIMEOUT cycles, req = 0 and done status 01; the next command is accepted.
REQ-039 Assert attention during RX_REL, in the same cycle ack falls. Required: done status 10 with req low.
REQ-040 Return 0xA5A5 with parity bit 0. Required with ESDI_CMD_PARITY_CHECK_EN: rsp_parity_err = 1 and done status 11. Required without it: rsp_parity_err = 0 and done status 00.

Source files
------------

// File: rtl/esdi_cmd_master.sv
// rtl/esdi_cmd_master.sv - ESDI serial command master with status word readback
//
// Sends a 16-bit command plus its odd-parity bit to an ESDI drive, one bit per
// transfer_req/transfer_ack handshake, MSB first. It then reads back
// cmd_rsp_words status words of 17 bits each (16 data bits MSB first, then
// parity) and waits for command_complete. Done pulses for one cycle with the
// status: 00 ok, 01 timeout, 10 attention, 11 parity error.
//
// Ports:
//   aclk, areset                      clock, asynchronous active-high reset
//   cmd_valid/cmd_ready               command handshake (accepted only in IDLE)
//   cmd_data[15:0], cmd_rsp_words[2:0] command word, status words to read back
//   rsp_valid/rsp_ready               status word handshake
//   rsp_data[15:0], rsp_parity_err    received status word and its parity flag
//   done, done_status[1:0], busy      completion pulse/status, activity flag
//   esdi_transfer_req, esdi_command_data                        drive outputs
//   esdi_transfer_ack, esdi_confstat_data,
//   esdi_command_complete, esdi_attention                       drive inputs (async)
//
// Configuration: define ESDI_CMD_PARITY_CHECK_EN to check status word parity.
// Without it the parity bit is received but discarded.
module esdi_cmd_master #(
  parameter int DATA_SETUP = 6,
  parameter int TIMEOUT    = 1_000_000
) (
  input  logic        aclk,
  input  logic        areset,
  input  logic        cmd_valid,
  output logic        cmd_ready,
  input  logic [15:0] cmd_data,
  input  logic [2:0]  cmd_rsp_words,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic [15:0] rsp_data,
  output logic        rsp_parity_err,
  output logic        done,
  output logic [1:0]  done_status,
  output logic        busy,
  output logic        esdi_transfer_req,
  output logic        esdi_command_data,
  input  logic        esdi_transfer_ack,
  input  logic        esdi_confstat_data,
  input  logic        esdi_command_complete,
  input  logic        esdi_attention
);

  localparam logic [3:0] S_IDLE     = 4'd0;
  localparam logic [3:0] S_TX_SETUP = 4'd1;
  localparam logic [3:0] S_TX_REQ   = 4'd2;
  localparam logic [3:0] S_TX_REL   = 4'd3;
  localparam logic [3:0] S_RX_REQ   = 4'd4;
  localparam logic [3:0] S_RX_REL   = 4'd5;
  localparam logic [3:0] S_RX_HOLD  = 4'd6;
  localparam logic [3:0] S_CMPL     = 4'd7;
  localparam logic [3:0] S_DONE     = 4'd8;

`ifdef ESDI_CMD_PARITY_CHECK_EN
  localparam int RXW = 17;
`else
  localparam int RXW = 16;
`endif

  // Two-flop synchronizers, bit order {attention, complete, confstat, ack}
  logic [3:0] sync1_q, sync2_q;
  logic       ack_s, conf_s, cmpl_s, attn_s;

  always_ff @(posedge aclk or posedge areset) begin
    if (areset) begin
      sync1_q <= '0;
      sync2_q <= '0;
    end else begin
      sync1_q <= {esdi_attention, esdi_command_complete, esdi_confstat_data, esdi_transfer_ack};
      sync2_q <= sync1_q;
    end
  end

  assign {attn_s, cmpl_s, conf_s, ack_s} = sync2_q;

  logic [3:0]     state_q, state_d;
  logic [16:0]    shift_q, shift_d;
  logic [RXW-1:0] rx_q, rx_d;
  logic [4:0]     bit_cnt_q, bit_cnt_d;
  logic [2:0]     words_q, words_d;
  logic [31:0]    wait_q, wait_d;
  logic           req_q, req_d;
  logic           cdata_q, cdata_d;
  logic           perr_q, perr_d;
  logic [1:0]     status_q, status_d;
  logic           word_perr;
  logic           tmo_state;

`ifdef ESDI_CMD_PARITY_CHECK_EN
  assign word_perr = ((~^rx_q[16:1]) != rx_q[0]);
`else
  assign word_perr = 1'b0;
`endif

  assign tmo_state = (state_q == S_TX_REQ) || (state_q == S_TX_REL) ||
                     (state_q == S_RX_REQ) || (state_q == S_RX_REL) ||
                     (state_q == S_CMPL);

  always_comb begin
    state_d   = state_q;
    shift_d   = shift_q;
    rx_d      = rx_q;
    bit_cnt_d = bit_cnt_q;
    words_d   = words_q;
    req_d     = req_q;
    cdata_d   = cdata_q;
    perr_d    = perr_q;
    status_d  = status_q;

    case (state_q)
      S_IDLE: begin
        if (cmd_valid) begin
          shift_d   = {cmd_data, ~^cmd_data};
          words_d   = cmd_rsp_words;
          bit_cnt_d = '0;
          perr_d    = 1'b0;
          cdata_d   = cmd_data[15];
          state_d   = S_TX_SETUP;
        end
      end
      S_TX_SETUP: begin
        cdata_d = shift_q[16];
        if (wait_q == 32'(DATA_SETUP - 1)) begin
          req_d   = 1'b1;
          state_d = S_TX_REQ;
        end
      end
      S_TX_REQ: begin
        if (ack_s) begin
          req_d     = 1'b0;
          shift_d   = {shift_q[15:0], 1'b0};
          bit_cnt_d = bit_cnt_q + 5'd1;
          state_d   = S_TX_REL;
        end
      end
      S_TX_REL: begin
        if (!ack_s) begin
          if (bit_cnt_q < 5'd17) begin
            // Next bit goes out on entry so it gets the full setup window
            cdata_d = shift_q[16];
            state_d = S_TX_SETUP;
          end else begin
            cdata_d   = 1'b0;
            bit_cnt_d = '0;
            state_d   = (words_q != 3'd0) ? S_RX_REQ : S_CMPL;
          end
        end
      end
      S_RX_REQ: begin
        req_d = 1'b1;
        if (ack_s) begin
          // Without parity checking the 17th (parity) bit is not shifted in
          if (RXW == 17 || bit_cnt_q != 5'd16)
            rx_d = {rx_q[RXW-2:0], conf_s};
          bit_cnt_d = bit_cnt_q + 5'd1;
          req_d     = 1'b0;
          state_d   = S_RX_REL;
        end
      end
      S_RX_REL: begin
        if (!ack_s) begin
          if (bit_cnt_q < 5'd17) begin
            state_d = S_RX_REQ;
          end else begin
            bit_cnt_d = '0;
            state_d   = S_RX_HOLD;
          end
        end
      end
      S_RX_HOLD: begin
        if (rsp_ready) begin
          perr_d  = perr_q | word_perr;
          words_d = words_q - 3'd1;
          state_d = (words_q == 3'd1) ? S_CMPL : S_RX_REQ;
        end
      end
      S_CMPL: begin
        if (cmpl_s) begin
          status_d = perr_q ? 2'b11 : 2'b00;
          state_d  = S_DONE;
        end
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase

    // Attention outranks timeout and ack; both abort with the lines released
    if (state_q != S_IDLE && state_q != S_DONE && attn_s) begin
      state_d  = S_DONE;
      status_d = 2'b10;
      req_d    = 1'b0;
      cdata_d  = 1'b0;
    end else if (tmo_state && wait_q == 32'(TIMEOUT)) begin
      state_d  = S_DONE;
      status_d = 2'b01;
      req_d    = 1'b0;
      cdata_d  = 1'b0;
    end

    wait_d = (state_d != state_q) ? '0 : wait_q + 32'd1;
  end

  always_ff @(posedge aclk or posedge areset) begin
    if (areset) begin
      state_q   <= S_IDLE;
      shift_q   <= '0;
      rx_q      <= '0;
      bit_cnt_q <= '0;
      words_q   <= '0;
      wait_q    <= '0;
      req_q     <= 1'b0;
      cdata_q   <= 1'b0;
      perr_q    <= 1'b0;
      status_q  <= 2'b00;
    end else begin
      state_q   <= state_d;
      shift_q   <= shift_d;
      rx_q      <= rx_d;
      bit_cnt_q <= bit_cnt_d;
      words_q   <= words_d;
      wait_q    <= wait_d;
      req_q     <= req_d;
      cdata_q   <= cdata_d;
      perr_q    <= perr_d;
      status_q  <= status_d;
    end
  end

  assign cmd_ready         = (state_q == S_IDLE);
  assign busy              = (state_q != S_IDLE);
  assign rsp_valid         = (state_q == S_RX_HOLD);
  assign rsp_data          = rx_q[RXW-1 -: 16];
  assign rsp_parity_err    = rsp_valid && word_perr;
  assign done              = (state_q == S_DONE);
  assign done_status       = status_q;
  assign esdi_transfer_req = req_q;
  assign esdi_command_data = cdata_q;

endmodule
